// File: rtl/multicycle_control.sv
// Multi-cycle MIPS sequencer: steps the shared datapath through
// fetch/decode/execute/memory/write-back, stalls on mem_ready, traps on
// unsupported opcodes and counts retired instructions.
module multicycle_control (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  op,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        pc_wr,
    output logic        pc_wr_cond,
    output logic        ir_wr,
    output logic        i_or_d,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic        reg_dst,
    output logic        mem_to_reg,
    output logic        reg_wr,
    output logic        ext_op,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [2:0]  alu_op,
    output logic [1:0]  pc_src,
    output logic        inst_done,
    output logic        illegal,
    output logic [15:0] instr_count
);

    localparam logic [5:0] OP_R     = 6'b000000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    typedef enum logic [3:0] {
        S_RST, S_FETCH, S_DECODE, S_EXEC_R, S_WB_R, S_EXEC_I, S_WB_I,
        S_ADDR, S_MEM_RD, S_WB_L, S_MEM_WR, S_BRANCH, S_JUMP, S_TRAP
    } state_t;

    state_t      state, next;
    logic [15:0] count_q;

    // The branch decision (pc_wr_cond & zero) is made in the datapath, so
    // the zero flag is not consumed by the sequencer itself.
    logic unused_zero;
    assign unused_zero = zero;

    // State register; reset drops any in-flight access immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_RST;
        else        state <= next;
    end

    // Next-state and control outputs; everything defaults to 0.
    always_comb begin
        next       = state;
        pc_wr      = 1'b0;
        pc_wr_cond = 1'b0;
        ir_wr      = 1'b0;
        i_or_d     = 1'b0;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_wr     = 1'b0;
        ext_op     = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = 3'b000;
        pc_src     = 2'b00;
        inst_done  = 1'b0;
        illegal    = 1'b0;
        case (state)
            S_RST: next = S_FETCH;
            S_FETCH: begin
                // IR and PC load only on the cycle the fetch completes.
                mem_rd    = 1'b1;
                alu_src_b = 2'b01;
                ir_wr     = mem_ready;
                pc_wr     = mem_ready;
                if (mem_ready) next = S_DECODE;
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                ext_op    = 1'b1;
                case (op)
                    OP_R:            next = S_EXEC_R;
                    OP_ADDIU, OP_ORI: next = S_EXEC_I;
                    OP_LW, OP_SW:    next = S_ADDR;
                    OP_BEQ:          next = S_BRANCH;
                    OP_J:            next = S_JUMP;
                    default:         next = S_TRAP;
                endcase
            end
            S_EXEC_R: begin
                alu_src_a = 1'b1;
                alu_op    = 3'b001;
                next      = S_WB_R;
            end
            S_WB_R: begin
                reg_dst   = 1'b1;
                reg_wr    = 1'b1;
                inst_done = 1'b1;
                next      = S_FETCH;
            end
            S_EXEC_I: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                if (op == OP_ORI) alu_op = 3'b010;
                else              ext_op = 1'b1;
                next = S_WB_I;
            end
            S_WB_I: begin
                reg_wr    = 1'b1;
                inst_done = 1'b1;
                next      = S_FETCH;
            end
            S_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                ext_op    = 1'b1;
                next      = (op == OP_SW) ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                mem_rd = 1'b1;
                i_or_d = 1'b1;
                if (mem_ready) next = S_WB_L;
            end
            S_WB_L: begin
                reg_wr     = 1'b1;
                mem_to_reg = 1'b1;
                inst_done  = 1'b1;
                next       = S_FETCH;
            end
            S_MEM_WR: begin
                // The store retires in the cycle memory accepts it.
                mem_wr    = 1'b1;
                i_or_d    = 1'b1;
                inst_done = mem_ready;
                if (mem_ready) next = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a  = 1'b1;
                alu_op     = 3'b100;
                pc_wr_cond = 1'b1;
                pc_src     = 2'b01;
                inst_done  = 1'b1;
                next       = S_FETCH;
            end
            S_JUMP: begin
                pc_wr     = 1'b1;
                pc_src    = 2'b10;
                inst_done = 1'b1;
                next      = S_FETCH;
            end
            S_TRAP: begin
                illegal = 1'b1;
                next    = S_TRAP;
            end
            default: next = S_RST;
        endcase
    end

    // Retired-instruction counter; wraps naturally at 16 bits.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)         count_q <= 16'd0;
        else if (inst_done) count_q <= count_q + 16'd1;
    end

    assign instr_count = count_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: instruction-level reference
// model compared every cycle, plus directed literal checks and random runs.
module tb_multicycle_control;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [5:0]  op = 6'd0;
    logic        zero = 1'b0;
    logic        mem_ready = 1'b1;
    logic        pc_wr, pc_wr_cond, ir_wr, i_or_d, mem_rd, mem_wr;
    logic        reg_dst, mem_to_reg, reg_wr, ext_op, alu_src_a;
    logic [1:0]  alu_src_b, pc_src;
    logic [2:0]  alu_op;
    logic        inst_done, illegal;
    logic [15:0] instr_count;

    multicycle_control dut (
        .clk(clk), .reset(reset), .op(op), .zero(zero), .mem_ready(mem_ready),
        .pc_wr(pc_wr), .pc_wr_cond(pc_wr_cond), .ir_wr(ir_wr), .i_or_d(i_or_d),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .reg_wr(reg_wr), .ext_op(ext_op),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .pc_src(pc_src), .inst_done(inst_done), .illegal(illegal),
        .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       pc_wr, pc_wr_cond, ir_wr, i_or_d, mem_rd, mem_wr;
        logic       reg_dst, mem_to_reg, reg_wr, ext_op, alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic [1:0] pc_src;
        logic       inst_done, illegal;
    } ctl_t;

    typedef enum logic [2:0] {K_R, K_ADDIU, K_ORI, K_LW, K_SW, K_BEQ, K_J, K_BAD} kind_t;

    localparam logic [5:0] OP_R = 6'b000000, OP_ADDIU = 6'b001001, OP_ORI = 6'b001101;
    localparam logic [5:0] OP_LW = 6'b100011, OP_SW = 6'b101011, OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_J = 6'b000010;

    int checks = 0;
    int errors = 0;

    ctl_t act;
    assign act = {pc_wr, pc_wr_cond, ir_wr, i_or_d, mem_rd, mem_wr, reg_dst,
                  mem_to_reg, reg_wr, ext_op, alu_src_a, alu_src_b, alu_op,
                  pc_src, inst_done, illegal};

    function automatic kind_t classify(input logic [5:0] o);
        case (o)
            OP_R:     return K_R;
            OP_ADDIU: return K_ADDIU;
            OP_ORI:   return K_ORI;
            OP_LW:    return K_LW;
            OP_SW:    return K_SW;
            OP_BEQ:   return K_BEQ;
            OP_J:     return K_J;
            default:  return K_BAD;
        endcase
    endfunction

    // Index of the final cycle of each instruction with no memory wait
    // (beq/j 3 cycles, lw 5, others 4; cycle 0 is fetch).
    function automatic int last_step(input kind_t k);
        case (k)
            K_LW:         return 4;
            K_BEQ, K_J:   return 2;
            default:      return 3;
        endcase
    endfunction

    // Expected controls for cycle s of an instruction of class k.
    function automatic ctl_t model_out(input logic r, input logic t, input kind_t k,
                                       input int s, input logic mr);
        ctl_t e;
        e = '0;
        if (r) begin
            e = '0;
        end else if (t) begin
            e.illegal = 1'b1;
        end else if (s == 0) begin
            e.mem_rd = 1'b1; e.alu_src_b = 2'b01; e.ir_wr = mr; e.pc_wr = mr;
        end else if (s == 1) begin
            e.alu_src_b = 2'b11; e.ext_op = 1'b1;
        end else begin
            case (k)
                K_R: if (s == 2) begin
                        e.alu_src_a = 1'b1; e.alu_op = 3'b001;
                     end else begin
                        e.reg_dst = 1'b1; e.reg_wr = 1'b1; e.inst_done = 1'b1;
                     end
                K_ADDIU, K_ORI: if (s == 2) begin
                        e.alu_src_a = 1'b1; e.alu_src_b = 2'b10;
                        e.ext_op = (k == K_ADDIU);
                        e.alu_op = (k == K_ORI) ? 3'b010 : 3'b000;
                     end else begin
                        e.reg_wr = 1'b1; e.inst_done = 1'b1;
                     end
                K_LW, K_SW: if (s == 2) begin
                        e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; e.ext_op = 1'b1;
                     end else if (s == 3 && k == K_LW) begin
                        e.mem_rd = 1'b1; e.i_or_d = 1'b1;
                     end else if (s == 3) begin
                        e.mem_wr = 1'b1; e.i_or_d = 1'b1; e.inst_done = mr;
                     end else begin
                        e.reg_wr = 1'b1; e.mem_to_reg = 1'b1; e.inst_done = 1'b1;
                     end
                K_BEQ: begin
                        e.alu_src_a = 1'b1; e.alu_op = 3'b100; e.pc_wr_cond = 1'b1;
                        e.pc_src = 2'b01; e.inst_done = 1'b1;
                     end
                K_J: begin
                        e.pc_wr = 1'b1; e.pc_src = 2'b10; e.inst_done = 1'b1;
                     end
                default: e = '0;
            endcase
        end
        return e;
    endfunction

    // Reference model: position within the current instruction.
    logic        m_rst = 1'b1;
    logic        m_trap = 1'b0;
    kind_t       m_kind = K_R;
    int          m_step = 0;
    logic [15:0] m_count = 16'd0;
    logic        preload_en = 1'b0;
    ctl_t        exp_now;

    assign exp_now = model_out(m_rst, m_trap, m_kind, m_step, mem_ready);

    // Advance the model one cycle; stall on memory-wait cycles.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_rst <= 1'b1; m_trap <= 1'b0; m_step <= 0; m_count <= 16'd0;
        end else if (m_rst) begin
            m_rst <= 1'b0; m_step <= 0;
        end else if (!m_trap) begin
            m_count <= (preload_en ? 16'hFFFE : m_count) + (exp_now.inst_done ? 16'd1 : 16'd0);
            if (m_step == 1) begin
                m_kind <= classify(op);
                if (classify(op) == K_BAD) m_trap <= 1'b1;
                else                       m_step <= 2;
            end else if (!mem_ready && (m_step == 0 ||
                         (m_step == 3 && (m_kind == K_LW || m_kind == K_SW)))) begin
                m_step <= m_step;
            end else if (m_step == last_step(m_kind)) begin
                m_step <= 0;
            end else begin
                m_step <= m_step + 1;
            end
        end
    end

    // Every-cycle comparison of DUT outputs against the model.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            checks++;
            if (act !== exp_now) begin
                errors++;
                $display("FAIL ctl t=%0t got %h expected %h", $time, act, exp_now);
            end
            checks++;
            if (instr_count !== m_count) begin
                errors++;
                $display("FAIL count t=%0t got %h expected %h", $time, instr_count, m_count);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    // Runs one instruction starting at its fetch cycle; fw/mw are the wait
    // cycles injected in fetch and in the data memory access.
    task automatic do_instr(input logic [5:0] o, input int fw, input int mw,
                            output int cyc, output int held, output int wr,
                            output logic [15:0] cnt);
        int f, m;
        logic done;
        f = fw; m = mw; cyc = 0; held = 0; wr = 0; cnt = 16'd0; done = 1'b0;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            op = o;
            zero = 1'($urandom_range(0, 1));
            if (m_step == 0) begin
                mem_ready = (f == 0); if (f > 0) f--;
            end else if (m_step == 3 && (m_kind == K_LW || m_kind == K_SW)) begin
                mem_ready = (m == 0); if (m > 0) m--;
            end else begin
                mem_ready = 1'($urandom_range(0, 1));
            end
            #3;
            cyc++;
            if (mem_rd && i_or_d) held++;
            if (reg_wr) wr++;
            if (inst_done) begin done = 1'b1; cnt = instr_count; end
        end
        check("instr_timeout", {31'd0, done}, 32'd1);
    endtask

    task automatic reset_dut();
        @(negedge clk);
        reset = 1'b0; mem_ready = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    function automatic logic [5:0] rand_bad();
        logic [5:0] o;
        o = 6'($urandom_range(0, 63));
        if (classify(o) != K_BAD) o = 6'h3F;
        return o;
    endfunction

    initial begin
        int cyc, held, wr, ill;
        logic [15:0] cnt;
        logic done;
        logic [5:0] legal [7];
        legal = '{OP_R, OP_ADDIU, OP_ORI, OP_LW, OP_SW, OP_BEQ, OP_J};

        // Reset held for three cycles: everything quiet.
        repeat (3) @(negedge clk);
        #3;
        check("reset_outputs", {12'd0, act}, 32'd0);
        check("reset_count", {16'd0, instr_count}, 32'd0);
        @(negedge clk);
        reset = 1'b1; mem_ready = 1'b1; op = OP_R;

        // First cycle after release is FETCH with ready memory.
        @(negedge clk);
        #3;
        check("fetch_mem_rd", {31'd0, mem_rd}, 32'd1);
        check("fetch_ir_wr", {31'd0, ir_wr}, 32'd1);
        check("fetch_pc_wr", {31'd0, pc_wr}, 32'd1);
        done = 1'b0;
        for (int i = 0; i < 10 && !done; i++) begin
            @(negedge clk); op = OP_R; mem_ready = 1'b1; #3;
            if (inst_done) done = 1'b1;
        end
        check("r_wb_seen", {31'd0, done}, 32'd1);
        check("r_wb_regs", {30'd0, reg_dst, reg_wr}, 32'd3);
        check("r_wb_count", {16'd0, instr_count}, 32'd0);

        do_instr(OP_R, 0, 0, cyc, held, wr, cnt);
        check("r_cycles", cyc, 4); check("r_regwr", wr, 1); check("r_count", {16'd0, cnt}, 1);
        do_instr(OP_LW, 0, 2, cyc, held, wr, cnt);
        check("lw_cycles", cyc, 7); check("lw_held", held, 3); check("lw_regwr", wr, 1);
        check("lw_count", {16'd0, cnt}, 2);
        do_instr(OP_BEQ, 0, 0, cyc, held, wr, cnt);
        check("beq_cycles", cyc, 3); check("beq_count", {16'd0, cnt}, 3);
        do_instr(OP_J, 0, 0, cyc, held, wr, cnt);
        check("j_cycles", cyc, 3); check("j_count", {16'd0, cnt}, 4);
        do_instr(OP_SW, 1, 0, cyc, held, wr, cnt);
        check("sw_fwait_cycles", cyc, 5); check("sw_regwr", wr, 0);
        do_instr(OP_ADDIU, 0, 0, cyc, held, wr, cnt);
        check("addiu_cycles", cyc, 4);
        do_instr(OP_ORI, 0, 0, cyc, held, wr, cnt);
        check("ori_cycles", cyc, 4); check("ori_count", {16'd0, cnt}, 7);

        // Unsupported opcode: fetch, decode, then trap forever.
        ill = 0;
        for (int i = 0; i < 22; i++) begin
            @(negedge clk); op = 6'h3F; mem_ready = 1'b1; #3;
            if (illegal) ill++;
        end
        check("trap_cycles", ill, 20);
        check("trap_count", {16'd0, instr_count}, 8);
        reset = 1'b0;
        #1;
        check("trap_cleared", {31'd0, illegal}, 32'd0);
        reset_dut();

        // Reset in the middle of a stalled store.
        do_instr(OP_J, 0, 0, cyc, held, wr, cnt);
        done = 1'b0;
        for (int i = 0; i < 10 && !done; i++) begin
            @(negedge clk); op = OP_SW;
            done = (m_step == 3 && m_kind == K_SW);
            mem_ready = !done;
        end
        #3;
        check("memwr_before", {31'd0, mem_wr}, 32'd1);
        check("memwr_count", {16'd0, instr_count}, 32'd1);
        reset = 1'b0;
        #1;
        check("memwr_async_drop", {30'd0, mem_wr, i_or_d}, 32'd0);
        check("memwr_count_clr", {16'd0, instr_count}, 32'd0);
        @(negedge clk);
        reset = 1'b1; mem_ready = 1'b1;

        // Counter wrap: preload near the top, then retire two instructions.
        do_instr(OP_J, 0, 0, cyc, held, wr, cnt);
        force dut.count_q = 16'hFFFE;
        preload_en = 1'b1;
        #1;
        release dut.count_q;
        @(posedge clk);
        #1;
        preload_en = 1'b0;
        do_instr(OP_J, 0, 0, cyc, held, wr, cnt);
        check("wrap_before", {16'd0, cnt}, 32'h0000FFFF);
        @(negedge clk); op = OP_R; mem_ready = 1'b1; #3;
        check("wrap_after", {16'd0, instr_count}, 32'd0);

        // Random instruction mix with memory stalls and async reset pulses.
        for (int c = 0; c < 6000; c++) begin
            @(negedge clk);
            zero = 1'($urandom_range(0, 1));
            if (m_step == 0 || m_rst)
                op = ($urandom_range(0, 24) == 0) ? rand_bad() : legal[$urandom_range(0, 6)];
            mem_ready = ($urandom_range(0, 9) < 7);
            if ((m_trap && $urandom_range(0, 3) == 0) || $urandom_range(0, 299) == 0) begin
                #3; reset = 1'b0; #1; reset = 1'b1;
            end
        end

        @(negedge clk);
        #4;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
